// File: rtl/dm_tx_streamer_pkg.sv
// Shared constants and FSM state type for the data-memory TX streamer.
package dm_tx_streamer_pkg;

  localparam int unsigned TxDataW     = 32;  // two data-path words per memory word
  localparam int unsigned TxAddrW     = 8;   // data memory address width
  localparam int unsigned TxRdLat     = 2;   // BRAM read latency (HIGH_PERFORMANCE)
  localparam int unsigned TxFifoDepth = 4;   // output FIFO entries

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StFin
  } tx_state_e;

endpackage

// File: rtl/dm_tx_streamer_tx_fifo.sv
// Small synchronous FIFO with first-word-fall-through head output.
module dm_tx_streamer_tx_fifo
  import dm_tx_streamer_pkg::*;
#(
  parameter int unsigned DATA_W = TxDataW,
  parameter int unsigned DEPTH  = TxFifoDepth
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [DATA_W-1:0]            i_data,
  input  logic                         i_pop,
  output logic [DATA_W-1:0]            o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage array; no reset needed since contents are only read when counted valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= (r_wr_ptr == PtrW'(DEPTH - 1)) ? '0 : r_wr_ptr + PtrW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= (r_rd_ptr == PtrW'(DEPTH - 1)) ? '0 : r_rd_ptr + PtrW'(1);
      end
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head word and status flags.
  always_comb begin
    o_data  = r_mem[r_rd_ptr];
    o_count = r_count;
    o_empty = (r_count == '0);
    o_full  = (r_count == CntW'(DEPTH));
  end

endmodule

// File: rtl/dm_tx_streamer.sv
// Reads a contiguous block from the data BRAM and streams it to the neighbouring PE
// over valid/ready. Read issue is credit-limited so the output FIFO can never overflow.
module dm_tx_streamer
  import dm_tx_streamer_pkg::*;
#(
  parameter int unsigned DATA_W     = TxDataW,
  parameter int unsigned ADDR_W     = TxAddrW,
  parameter int unsigned RD_LAT     = TxRdLat,
  parameter int unsigned FIFO_DEPTH = TxFifoDepth
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_rden,
  output logic [ADDR_W-1:0] o_mem_raddr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_tx_valid,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_last,
  input  logic              i_tx_ready
);

  localparam int unsigned CntW     = ADDR_W + 1;
  localparam int unsigned InflW    = $clog2(RD_LAT + 1);
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);

  tx_state_e             r_state;
  tx_state_e             w_state_next;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [CntW-1:0]       r_issue_cnt;
  logic [CntW-1:0]       r_send_cnt;
  logic [RD_LAT-1:0]     r_tags;

  logic [InflW-1:0]      w_inflight;
  logic [31:0]           w_credit_used;
  logic                  w_issue;
  logic                  w_pop;
  logic [DATA_W-1:0]     w_fifo_data;
  logic [FifoCntW-1:0]   w_fifo_count;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;

  // Count reads still travelling through the BRAM pipeline.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + InflW'(r_tags[i]);
    end
  end

  // Issue only when every outstanding read is guaranteed a FIFO slot on arrival.
  always_comb begin
    w_credit_used = 32'(w_inflight) + 32'(w_fifo_count);
    w_issue       = (r_state == StIssue) && (r_issue_cnt != '0) &&
                    (w_credit_used < FIFO_DEPTH) && !w_fifo_full;
    w_pop         = !w_fifo_empty && i_tx_ready;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; start is only honoured in idle.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = (i_len != '0) ? StIssue : StFin;
        end
      end
      StIssue: begin
        if (w_issue && (r_issue_cnt == CntW'(1))) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        if (w_pop && (r_send_cnt == CntW'(1))) begin
          w_state_next = StFin;
        end
      end
      StFin:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Read pointer and word counters; the pointer wraps naturally at the memory size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_issue_cnt <= '0;
      r_send_cnt  <= '0;
    end else if ((r_state == StIdle) && i_start) begin
      r_rd_ptr    <= i_base_addr;
      r_issue_cnt <= i_len;
      r_send_cnt  <= i_len;
    end else begin
      if (w_issue) begin
        r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
        r_issue_cnt <= r_issue_cnt - CntW'(1);
      end
      if (w_pop) begin
        r_send_cnt <= r_send_cnt - CntW'(1);
      end
    end
  end

  // Tag shift register: a tag leaving the last stage marks valid read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tags <= '0;
    end else begin
      r_tags[0] <= w_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tags[i] <= r_tags[i-1];
      end
    end
  end

  dm_tx_streamer_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_tags[RD_LAT-1]),
    .i_data  (i_mem_rdata),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // FSM and stream outputs; rden stays high while reads drain so the BRAM output stage advances.
  always_comb begin
    o_busy      = (r_state == StIssue) || (r_state == StDrain);
    o_done      = (r_state == StFin);
    o_mem_rden  = w_issue || (|r_tags);
    o_mem_raddr = r_rd_ptr;
    o_tx_valid  = !w_fifo_empty;
    o_tx_data   = w_fifo_data;
    o_tx_last   = !w_fifo_empty && (r_send_cnt == CntW'(1));
  end

endmodule

// File: tb/tb_dm_tx_streamer.sv
// Directed bench for dm_tx_streamer with a 2-cycle-latency BRAM model holding mem[a] = a + 0x100.
module tb_dm_tx_streamer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  base;
  logic [8:0]  len;
  logic        busy;
  logic        done;
  logic        rden;
  logic [7:0]  raddr;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_last;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  logic [31:0] bram_s1;
  logic [31:0] bram_s2;

  logic [31:0] got_data [$];
  bit          got_last [$];
  int          done_cnt   = 0;
  int          rden_cnt   = 0;
  int          stall_viol = 0;

  dm_tx_streamer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (start),
    .i_base_addr (base),
    .i_len       (len),
    .o_busy      (busy),
    .o_done      (done),
    .o_mem_rden  (rden),
    .o_mem_raddr (raddr),
    .i_mem_rdata (rdata),
    .o_tx_valid  (tx_valid),
    .o_tx_data   (tx_data),
    .o_tx_last   (tx_last),
    .i_tx_ready  (tx_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h100 + 32'(i);
  end

  // Two-stage BRAM read pipeline, advanced by enb.
  always @(posedge clk) begin
    if (rden) begin
      bram_s1 <= mem[raddr];
      bram_s2 <= bram_s1;
    end
  end
  assign rdata = bram_s2;

  // Stream monitor on the falling edge: collects handshakes, counts pulses, checks stall stability.
  initial begin
    bit          prev_stall;
    logic [31:0] prev_data;
    bit          prev_last;
    prev_stall = 0;
    prev_data  = '0;
    prev_last  = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall && !(tx_valid && tx_data === prev_data && tx_last === prev_last))
          stall_viol++;
        if (tx_valid && tx_ready) begin
          got_data.push_back(tx_data);
          got_last.push_back(tx_last);
        end
        if (done) done_cnt++;
        if (rden) rden_cnt++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_last  = tx_last;
      end else begin
        prev_stall = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Start strobe for one cycle; returns in the first cycle after the accepting edge.
  task automatic pulse_start(input logic [7:0] b, input logic [8:0] l);
    base  = b;
    len   = l;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  // Advances until done is seen; cyc counts cycles since the start edge.
  task automatic wait_done(input int budget, output int cyc);
    cyc = 1;
    while (!done && cyc < budget) begin
      next_cycle();
      cyc++;
    end
  endtask

  task automatic check_words(input string tag, input logic [7:0] b, input int n);
    int bad;
    int nlast;
    check({tag, "_count"}, 64'(got_data.size()), 64'(n));
    bad   = 0;
    nlast = 0;
    for (int i = 0; i < got_data.size() && i < n; i++) begin
      logic [7:0] a;
      a = b + 8'(i);
      if (got_data[i] !== (32'h100 + 32'(a))) bad++;
      if (got_last[i]) nlast++;
    end
    check({tag, "_data_errs"}, 64'(bad), 64'd0);
    check({tag, "_last_count"}, 64'(nlast), 64'd1);
    if (got_last.size() == n) check({tag, "_last_on_final"}, 64'(got_last[n-1]), 64'd1);
  endtask

  initial begin
    int cyc;
    bit seen;
    logic [7:0] a;
    int dsnap;

    rst_n    = 1'b0;
    start    = 1'b0;
    base     = '0;
    len      = '0;
    tx_ready = 1'b1;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rden", rden, 0);
    check("rst_raddr", raddr, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_last", tx_last, 0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Basic: base 0x10, len 4, ready held high.
    got_data.delete();
    got_last.delete();
    pulse_start(8'h10, 9'd4);
    for (int c = 1; c <= 8; c++) begin
      if (c <= 4) begin
        check($sformatf("basic_rden_c%0d", c), rden, 1);
        check($sformatf("basic_raddr_c%0d", c), raddr, 64'(8'h10 + 8'(c - 1)));
      end
      if (c <= 3) check($sformatf("basic_txv_c%0d", c), tx_valid, 0);
      if (c >= 4 && c <= 7) begin
        check($sformatf("basic_txv_c%0d", c), tx_valid, 1);
        check($sformatf("basic_data_c%0d", c), tx_data, 64'(32'h110 + 32'(c - 4)));
        check($sformatf("basic_last_c%0d", c), tx_last, (c == 7) ? 1 : 0);
      end
      if (c <= 7) begin
        check($sformatf("basic_busy_c%0d", c), busy, 1);
        check($sformatf("basic_done_c%0d", c), done, 0);
      end
      if (c == 8) begin
        check("basic_done_c8", done, 1);
        check("basic_busy_c8", busy, 0);
        check("basic_txv_c8", tx_valid, 0);
      end
      next_cycle();
    end
    check("basic_done_c9", done, 0);

    // Wrap: base 0xFE, len 4; a start pulsed mid-transfer must be ignored.
    pulse_start(8'hFE, 9'd4);
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) begin
        base  = 8'h40;
        len   = 9'd2;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      a = 8'hFE + 8'(c - 1);
      if (c <= 4) check($sformatf("wrap_raddr_c%0d", c), raddr, 64'(a));
      if (c >= 4 && c <= 7) begin
        a = 8'hFE + 8'(c - 4);
        check($sformatf("wrap_data_c%0d", c), tx_data, 64'(32'h100 + 32'(a)));
        check($sformatf("wrap_last_c%0d", c), tx_last, (c == 7) ? 1 : 0);
      end
      if (c == 8) check("wrap_done_c8", done, 1);
      next_cycle();
    end
    check("wrap_idle_after_ignored_start", busy, 0);

    // Backpressure: start on the cycle right after done, ready 1-on/3-off.
    got_data.delete();
    got_last.delete();
    done_cnt   = 0;
    stall_viol = 0;
    base       = 8'h00;
    len        = 9'd8;
    start      = 1'b1;
    tx_ready   = 1'b0;
    seen       = 0;
    for (int n = 1; n <= 100; n++) begin
      next_cycle();
      if (n == 1) begin
        start = 1'b0;
        check("bp_accept_busy", busy, 1);
      end
      if (done) begin
        seen = 1;
        break;
      end
      tx_ready = (n % 4 == 0);
    end
    check("bp_done_seen", seen, 1);
    tx_ready = 1'b1;
    next_cycle();
    check_words("bp", 8'h00, 8);
    check("bp_stall_stable", 64'(stall_viol), 0);
    check("bp_done_pulses", 64'(done_cnt), 1);

    // Zero length: done next cycle, no reads, no words.
    got_data.delete();
    got_last.delete();
    rden_cnt = 0;
    pulse_start(8'h33, 9'd0);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    check("len0_rden", rden, 0);
    check("len0_txv", tx_valid, 0);
    next_cycle();
    check("len0_done_clear", done, 0);
    next_cycle();
    check("len0_rden_cnt", 64'(rden_cnt), 0);
    check("len0_words", 64'(got_data.size()), 0);

    // Full length from 0x80 wrapping through 0x7F.
    got_data.delete();
    got_last.delete();
    pulse_start(8'h80, 9'd256);
    wait_done(400, cyc);
    check("full_done_seen", done, 1);
    check("full_done_cycle", 64'(cyc), 64'd260);
    next_cycle();
    check_words("full", 8'h80, 256);
    if (got_data.size() == 256) check("full_last_word", got_data[255], 32'h17F);

    // Reset after three of eight words.
    got_data.delete();
    got_last.delete();
    pulse_start(8'h00, 9'd8);
    for (int c = 2; c <= 7; c++) next_cycle();
    check("rst_mid_words_before", 64'(got_data.size()), 3);
    check("rst_mid_txv_before", tx_valid, 1);
    dsnap = done_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_mid_txv", tx_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rden", rden, 0);
    check("rst_mid_done", done, 0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    next_cycle();
    check("rst_mid_no_done", 64'(done_cnt), 64'(dsnap));
    got_data.delete();
    got_last.delete();
    pulse_start(8'h20, 9'd3);
    wait_done(50, cyc);
    check("rst_after_done_seen", done, 1);
    check("rst_after_done_cycle", 64'(cyc), 64'd7);
    next_cycle();
    check_words("rst_after", 8'h20, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_tx_streamer.md
Name: dm_tx_streamer

Overview:
Read-side streamer for a PE's data memory, the transmitter end of the PE-to-PE TX path.
- On a start command, it reads a contiguous block of words from the simple-dual-port data BRAM (HIGH_PERFORMANCE, 2-cycle read latency).
- It presents those words as a valid/ready stream toward the neighbouring PE, whose data memory writes them into its alpha[k-1] region.
- Backpressure is handled with credit-limited read issue and a small output FIFO, so no word is ever dropped.

Parameters:
DATA_W, 32, word width (`DATA_WIDTH*2).
ADDR_W, 8, data memory address width (`DM_ADDR_WIDTH); memory depth is 2**ADDR_W.
RD_LAT, 2, BRAM read latency from address/rden to valid mem_rdata.
FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LAT+2 for full throughput.

Ports:
clk  in  1  single clock, all logic rising-edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle command strobe; sampled only in IDLE.
base_addr  in  ADDR_W  first read address.
len  in  ADDR_W+1  word count, 0..256.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse when a transfer completes.
mem_rden  out  1  BRAM read enable (enb).
mem_raddr  out  ADDR_W  BRAM read address (addrb).
mem_rdata  in  DATA_W  BRAM read data (doutb), valid RD_LAT cycles after issue.
tx_valid  out  1  stream word valid.
tx_data  out  DATA_W  stream word.
tx_last  out  1  qualifies the final word of the transfer.
tx_ready  in  1  downstream accept; a transfer occurs when tx_valid && tx_ready.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; all outputs 0; counters, FIFO pointers and in-flight tags cleared.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - start with len>0 → latch base_addr into rd_ptr, latch len into issue_cnt and send_cnt → ISSUE.
  - start with len==0 → FIN, with no reads and no tx words.
  - start is ignored in every other state.
- ISSUE:
  - Each cycle, issue one read (mem_rden=1, mem_raddr=rd_ptr) iff inflight + fifo_count < FIFO_DEPTH and issue_cnt>0.
  - On each issue: rd_ptr increments modulo 2**ADDR_W (0xFF wraps to 0x00); issue_cnt decrements.
  - issue_cnt reaches 0 → DRAIN.
- In-flight tracking:
  - A RD_LAT-deep tag shift register marks issued reads.
  - When a tag exits, mem_rdata is pushed into the FIFO. The credit rule guarantees the FIFO is never full on a push.
  - mem_rden is held 1 while any tag is in flight, so the BRAM latch stage advances.
- Output side:
  - tx_valid = FIFO non-empty; tx_data = FIFO head.
  - tx_last = tx_valid && send_cnt==1.
  - Each handshake pops the FIFO and decrements send_cnt.
- DRAIN: send_cnt reaches 0 on a handshake → FIN.
- FIN: done=1 for exactly one cycle, busy=0 → IDLE. A start in the cycle after FIN is accepted.
- busy=1 in ISSUE and DRAIN only.
- Latency: start sampled at edge N → first read issued in cycle N+1 → first tx_valid in cycle N+4.
  - With tx_ready held high: one word per cycle, no bubbles.
  - done fires in cycle N+4+len.
- Simultaneous FIFO push and pop in one cycle: count unchanged, ordering preserved.
- tx_ready low: tx_valid/tx_data/tx_last stay stable until the handshake. Reads stall only via the credit rule.
- Reset mid-transfer: everything is discarded immediately; tx_valid drops asynchronously; no done pulse.

Decomposition:
- parameters.vh gains TX_FIFO_DEPTH and reuses DATA_WIDTH and DM_ADDR_WIDTH.
- FSM state encodings are localparams inside the module.
- One natural sub-module: tx_fifo, a synchronous FIFO with async active-low reset, push/pop/count/full/empty, and first-word-fall-through head output.

Test Plan:
- Basic: memory preloaded with mem[a]=a+0x100; start, base=0x10, len=4, tx_ready=1 → tx_data 0x110,0x111,0x112,0x113 on consecutive cycles N+4..N+7; tx_last only on 0x113; done at N+8.
- Wrap: base=0xFE, len=4 → mem_raddr sequence FE,FF,00,01; data 0x1FE,0x1FF,0x100,0x101.
- Backpressure: base=0, len=8, tx_ready toggled 1-cycle-on/3-off → all 8 words in order, none lost or duplicated; inflight+fifo_count never exceeds 4; tx_data stable while stalled.
- len=0 and full length: len=0 → done one cycle after start, no mem_rden, no tx_valid; len=256 from base 0x80 → 256 words, last word from address 0x7F.
- Command rules: start pulsed during busy → ignored, transfer unchanged; start on the cycle after done → new transfer accepted.
- Reset mid-stream: assert rst_n=0 after 3 of 8 words → tx_valid, busy and mem_rden are 0 at once; no done; a fresh start after release streams correctly.
